// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds the controller state enum, opcode/funct constants and the
// encodings of the ALU, next-PC, ALU-B and shift selects.
package mips_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRtypeEx,
    StRtypeWb,
    StBranchEx,
    StImmEx,
    StImmWb,
    StJEx
  } state_e;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type shift functs
  localparam logic [5:0] FunctSll = 6'b000000;
  localparam logic [5:0] FunctSrl = 6'b000010;
  localparam logic [5:0] FunctSra = 6'b000011;

  // aluctl encodings
  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluFunct = 3'b010;
  localparam logic [2:0] AluAnd   = 3'b011;
  localparam logic [2:0] AluOr    = 3'b100;

  // pcsrc encodings
  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  // alusrcb encodings
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // Register file shift modes
  localparam logic [1:0] ShNone = 2'b00;
  localparam logic [1:0] ShSll  = 2'b01;
  localparam logic [1:0] ShSrl  = 2'b10;
  localparam logic [1:0] ShSra  = 2'b11;

  function automatic logic [1:0] shift_of(logic [5:0] funct);
    logic [1:0] sh;
    case (funct)
      FunctSll: sh = ShSll;
      FunctSrl: sh = ShSrl;
      FunctSra: sh = ShSra;
      default:  sh = ShNone;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/memwait_cnt.sv
// Memory wait counter.
// Counts cycles in which an outstanding memory access is not answered.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   clr        : restart the count (state entry)
//   inc        : one more unanswered cycle
//   lim        : number of unanswered cycles tolerated
//   cnt        : current count
//   expired    : this unanswered cycle brings the count to lim
module memwait_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [Width-1:0] lim,
  output logic [Width-1:0] cnt,
  output logic             expired
);

  localparam logic [Width-1:0] CntOne = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  // Fires in the cycle whose increment would reach lim; a ready memory never increments.
  assign expired = inc && (cnt_q == lim - CntOne);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS controller.
// Moore FSM sequencing fetch/decode/execute/memory/write-back for lw, sw,
// R-type, beq, bne, addi, andi, ori and j, with a bounded memory wait.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   op, funct, zero   : instruction fields (from IR) and ALU zero flag
//   mem_ready         : memory completes the current access this cycle
//   pc_hold           : PC enable, 0 = load, 1 = hold
//   iord, mem_req, memwrite, irwrite : memory side controls
//   regdst, memtoreg, regwrite, shift : register file controls
//   alusrca, alusrcb, extsel, aluctl  : ALU controls
//   pcsrc             : next-PC select
//   illegal, timeout  : one-cycle error pulses
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_hold,
  output logic       iord,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       extsel,
  output logic [2:0] aluctl,
  output logic [1:0] pcsrc,
  output logic       illegal,
  output logic       timeout
);

  localparam int unsigned      CntW    = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0]  WaitLim = CntW'(MAX_WAIT);

  state_e          state_q, state_d;
  logic            in_wait, tmo, op_known;
  logic            pcwrite, beq_st, bne_st;
  logic            cnt_clr, cnt_inc;
  logic [CntW-1:0] wait_cnt;
  logic            unused_wait_cnt;

  assign in_wait  = state_q inside {StFetch, StMemRd, StMemWr};
  assign op_known = op inside {OpLw, OpSw, OpRtype, OpBeq, OpBne, OpAddi, OpAndi, OpOri, OpJ};
  assign cnt_inc  = in_wait & ~mem_ready;
  // A timed-out fetch stays in Fetch but counts as a fresh entry.
  assign cnt_clr  = (state_d != state_q) | tmo | ~in_wait;

  memwait_cnt #(
    .Width(CntW)
  ) u_memwait_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .lim    (WaitLim),
    .cnt    (wait_cnt),
    .expired(tmo)
  );

  // The count itself is only of debug interest here.
  assign unused_wait_cnt = ^wait_cnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (op)
          OpLw, OpSw:             state_d = StMemAdr;
          OpRtype:                state_d = StRtypeEx;
          OpBeq, OpBne:           state_d = StBranchEx;
          OpAddi, OpAndi, OpOri:  state_d = StImmEx;
          OpJ:                    state_d = StJEx;
          default:                state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (tmo) begin
          state_d = StFetch;
        end
      end
      StMemWr: begin
        if (mem_ready || tmo) begin
          state_d = StFetch;
        end
      end
      StRtypeEx:  state_d = StRtypeWb;
      StImmEx:    state_d = StImmWb;
      StMemWb, StRtypeWb, StBranchEx, StImmWb, StJEx: state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    iord     = 1'b0;
    mem_req  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    shift    = ShNone;
    alusrca  = 1'b0;
    alusrcb  = SrcBReg;
    extsel   = 1'b0;
    aluctl   = AluAdd;
    pcsrc    = PcAlu;
    illegal  = 1'b0;
    timeout  = 1'b0;
    pcwrite  = 1'b0;
    beq_st   = 1'b0;
    bne_st   = 1'b0;
    // Everything stays quiet while reset is held.
    if (reset) begin
      unique case (state_q)
        StFetch: begin
          mem_req = ~tmo;
          alusrcb = SrcBFour;
          irwrite = mem_ready;
          pcwrite = mem_ready;
          timeout = tmo;
        end
        StDecode: begin
          alusrcb = SrcBImmSh;
          illegal = ~op_known;
        end
        StMemAdr: begin
          alusrca = 1'b1;
          alusrcb = SrcBImm;
        end
        StMemRd: begin
          iord    = 1'b1;
          mem_req = ~tmo;
          timeout = tmo;
        end
        StMemWr: begin
          iord     = 1'b1;
          mem_req  = ~tmo;
          memwrite = ~tmo;
          timeout  = tmo;
        end
        StMemWb: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        StRtypeEx: begin
          alusrca = 1'b1;
          aluctl  = AluFunct;
        end
        StRtypeWb: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
          shift    = shift_of(funct);
        end
        StBranchEx: begin
          alusrca = 1'b1;
          aluctl  = AluSub;
          pcsrc   = PcAluOut;
          beq_st  = (op == OpBeq);
          bne_st  = (op == OpBne);
        end
        StImmEx: begin
          alusrca = 1'b1;
          alusrcb = SrcBImm;
          case (op)
            OpAndi: begin
              aluctl = AluAnd;
              extsel = 1'b1;
            end
            OpOri: begin
              aluctl = AluOr;
              extsel = 1'b1;
            end
            default: aluctl = AluAdd;
          endcase
        end
        StImmWb: regwrite = 1'b1;
        StJEx: begin
          pcwrite = 1'b1;
          pcsrc   = PcJump;
        end
        default: ;
      endcase
    end
  end

  // Branch resolution needs the live zero flag, so pc_hold is not registered.
  assign pc_hold = ~(pcwrite | (beq_st & zero) | (bne_st & ~zero));

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 15, which is the memory-wait cycles tolerated before timeout.
REQ-002 The block SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
REQ-003 The block SHALL have ports:
- op  in  6  instruction opcode.
- funct  in  6  R-type function field.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
REQ-004 The block SHALL have ports:
- pc_hold  out  1  PC register enable, flopr polarity: 0 = load, 1 = hold.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_req  out  1  memory access request.
- memwrite  out  1  write strobe.
- irwrite  out  1  instruction register load.
REQ-005 The block SHALL have ports:
- regdst  out  1  destination register select: 0 = rt, 1 = rd.
- memtoreg  out  1  write-back data select: 0 = ALU, 1 = memory.
- regwrite  out  1  register file write enable.
- shift  out  2  register file shift mode.
REQ-006 The block SHALL have ports:
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2.
- extsel  out  1  immediate extension: 0 = sign, 1 = zero.
- aluctl  out  3  ALU operation: 000 add, 001 sub, 010 funct, 011 and, 100 or.
REQ-007 The block SHALL have ports:
- pcsrc  out  2  next-PC select: 00 = ALU, 01 = ALU result register, 10 = jump target.
- illegal  out  1  one-cycle pulse flagging an unsupported opcode.
- timeout  out  1  one-cycle pulse flagging a memory timeout.

Function
REQ-008 The block SHALL be a Moore state machine with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BRANCHEX, IMMEX, IMMWB, JEX; the only exception is pc_hold, which is combinational in zero.
REQ-009 The block SHALL compute pc_hold = ~(pcwrite | (beq_st & zero) | (bne_st & ~zero)), where pcwrite, beq_st and bne_st are internal state decodes.
REQ-010 In FETCH the block SHALL assert mem_req, iord=0, alusrca=0, alusrcb=01, aluctl=000 and pcsrc=00; irwrite and pcwrite SHALL assert only in the cycle where mem_ready=1, after which the state goes to DECODE.
REQ-011 In DECODE the block SHALL drive alusrca=0, alusrcb=11 and aluctl=000, then branch on op:
- lw (100011) or sw (101011) -> MEMADR.
- R-type (000000) -> RTYPEEX.
- beq (000100) or bne (000101) -> BRANCHEX.
- addi (001000), andi (001100) or ori (001101) -> IMMEX.
- j (000010) -> JEX.
- any other opcode -> FETCH with illegal=1 for that cycle.
REQ-012 MEMADR SHALL drive alusrca=1, alusrcb=10 and aluctl=000, then go to MEMRD for lw or MEMWR for sw.
REQ-013 MEMRD and MEMWR SHALL hold iord=1 and mem_req=1 until mem_ready=1:
- MEMWR asserts memwrite throughout the wait and returns to FETCH on mem_ready.
- MEMRD goes to MEMWB on mem_ready.
REQ-014 MEMWB SHALL assert regwrite with regdst=0 and memtoreg=1, then go to FETCH.
REQ-015 RTYPEEX SHALL drive alusrca=1, alusrcb=00 and aluctl=010, then go to RTYPEWB.
REQ-016 RTYPEWB SHALL assert regwrite with regdst=1 and memtoreg=0, and SHALL set shift from funct: sll (000000) -> 01, srl (000010) -> 10, sra (000011) -> 11, anything else -> 00; it then goes to FETCH.
REQ-017 BRANCHEX SHALL drive alusrca=1, alusrcb=00, aluctl=001 and pcsrc=01, and SHALL raise beq_st or bne_st according to op; it then goes to FETCH.
REQ-018 IMMEX SHALL drive alusrca=1 and alusrcb=10, with these op-dependent settings:
- addi: aluctl=000, extsel=0.
- andi: aluctl=011, extsel=1.
- ori: aluctl=100, extsel=1.
IMMWB SHALL assert regwrite with regdst=0 and memtoreg=0.
REQ-019 JEX SHALL assert pcwrite with pcsrc=10, then go to FETCH.
REQ-020 A wait counter SHALL reset to 0 on entry to every wait state and increment each cycle mem_ready=0; when it reaches MAX_WAIT the block SHALL pulse timeout, drop mem_req and go to FETCH with no PC, IR or register write.
REQ-021 When mem_ready=1 in the cycle the counter reaches MAX_WAIT, completion SHALL win and timeout SHALL NOT pulse.
REQ-022 All outputs not listed for a state SHALL be 0, except pc_hold, which SHALL be 1.
REQ-023 op and funct SHALL be sampled from the instruction register and held stable from DECODE to the end of the instruction; the block SHALL NOT latch them.

Reset
REQ-024 When reset=0 at a rising clk edge, the state SHALL become FETCH and the wait counter SHALL become 0; this applies from any state, including mid-wait.
REQ-025 While reset=0, all outputs SHALL be 0 except pc_hold=1, so that no memory, register or PC write occurs.

Structure
REQ-026 The shared package mips_pkg SHALL hold the state enum, the opcode and funct constants, and the aluctl and pcsrc encodings.
REQ-027 The wait counter SHALL be the single sub-module memwait_cnt, with inputs clr, inc and lim and outputs cnt and expired.

Verification
REQ-028 The bench SHALL run lw with mem_ready held 1: the state sequence is FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH over 5 cycles, with regwrite=1 and memtoreg=1 only in cycle 5.
REQ-029 The bench SHALL run sw with mem_ready low for 3 cycles: memwrite=1 for 4 cycles and the block returns to FETCH; regwrite stays 0 throughout.
REQ-030 The bench SHALL run beq with zero=1, then bne with zero=1: pc_hold=0 in BRANCHEX for beq and pc_hold=1 for bne.
REQ-031 The bench SHALL run R-type sra (funct 000011): RTYPEWB shows shift=11, regdst=1 and regwrite=1.
REQ-032 The bench SHALL hold mem_ready=0 in FETCH with MAX_WAIT=15: timeout pulses at the 15th wait cycle, irwrite never asserts, and the state returns to FETCH.
REQ-033 The bench SHALL drive op=111111, then separately assert reset=0 during a MEMRD wait: illegal pulses for one cycle, and the reset sends the state to FETCH on the next edge with all write strobes at 0.
